// File: rtl/mc_ctrl_pkg.sv
// Shared types for the extended multicycle MIPS controller: state encoding, opcodes and
// control-field encodings. MC_CTRL_ILLEGAL_TRAP_EN adds the trap bit to the control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRtEnd  = 4'd7,
    StBeq    = 4'd8,
    StBne    = 4'd9,
    StIExec  = 4'd10,
    StIEnd   = 4'd11,
    StJump   = 4'd12,
    StTrap   = 4'd13
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  typedef enum logic [3:0] {
    OpcIll, OpcR, OpcLw, OpcSw, OpcBeq, OpcBne, OpcAddi, OpcAndi, OpcOri, OpcSlti, OpcJ
  } op_class_e;

  typedef enum logic [2:0] {
    AluAdd   = 3'd0,
    AluSub   = 3'd1,
    AluFunct = 3'd2,
    AluAnd   = 3'd3,
    AluOr    = 3'd4,
    AluSlt   = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {SrcBReg, SrcBFour, SrcBImm, SrcBImmSh} alu_src_b_e;
  typedef enum logic [1:0] {PcSrcAlu, PcSrcAluOut, PcSrcJump, PcSrcTrap} pc_src_e;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       is_bne;
    pc_src_e    pc_source;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    logic       ext_op;
    logic       reg_dst;
    logic       reg_write;
    alu_op_e    alu_op;
    logic       illegal;
    logic       retire;
    logic       mem_gate;  // strobes in this state only fire once memory completes
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       trap;
`endif
  } ctrl_t;

  function automatic op_class_e op_class(logic [5:0] op);
    case (op)
      OpRType: return OpcR;
      OpLw:    return OpcLw;
      OpSw:    return OpcSw;
      OpBeq:   return OpcBeq;
      OpBne:   return OpcBne;
      OpAddi:  return OpcAddi;
      OpAndi:  return OpcAndi;
      OpOri:   return OpcOri;
      OpSlti:  return OpcSlti;
      OpJ:     return OpcJ;
      default: return OpcIll;
    endcase
  endfunction

  function automatic alu_op_e imm_alu_op(op_class_e c);
    case (c)
      OpcAndi: return AluAnd;
      OpcOri:  return AluOr;
      OpcSlti: return AluSlt;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_ext_if.sv
// Controller <-> datapath bundle. The controller uses master; the datapath/memory side uses slave.
// The trap signal exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_control_ext_if #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 32
);
  logic [OP_W-1:0]    Op;
  logic               Zero;
  logic               mem_ready;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               IRWrite;
  logic [1:0]         PCSource;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               ExtOp;
  logic               RegDst;
  logic               RegWrite;
  logic               PCSel;
  logic [ALUOP_W-1:0] ALUOp;
  logic               illegal_op;
  logic [CNT_W-1:0]   instr_count;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic               trap;
`endif

  modport master (
    input  Op, Zero, mem_ready,
    output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA, ALUSrcB, ExtOp,
           RegDst, RegWrite, PCSel, ALUOp, illegal_op, instr_count
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , output trap
`endif
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA, ALUSrcB, ExtOp,
           RegDst, RegWrite, PCSel, ALUOp, illegal_op, instr_count
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , input trap
`endif
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state + opcode -> control word (Moore decode, before mem_ready gating).
// With MC_CTRL_ILLEGAL_TRAP_EN the illegal flag moves from DECODE to the TRAP state.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  output ctrl_t           cw_o,
  output op_class_e       opc_o
);

  always_comb begin
    // Any set bit above the 6-bit opcode field makes the opcode undecodable
    opc_o = (|(op_i >> 6)) ? OpcIll : op_class(6'(op_i));

    cw_o        = '0;
    cw_o.ext_op = 1'b1;

    unique case (state_i)
      StFetch: begin
        cw_o.mem_read  = 1'b1;
        cw_o.alu_src_b = SrcBFour;
        cw_o.ir_write  = 1'b1;
        cw_o.pc_write  = 1'b1;
        cw_o.mem_gate  = 1'b1;
      end
      StDecode: begin
        cw_o.alu_src_b = SrcBImmSh;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        cw_o.illegal   = (opc_o == OpcIll);
`endif
      end
      StMemAdr: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        cw_o.mem_read = 1'b1;
        cw_o.iord     = 1'b1;
      end
      StMemWb: begin
        cw_o.reg_write  = 1'b1;
        cw_o.mem_to_reg = 1'b1;
        cw_o.retire     = 1'b1;
      end
      StMemWr: begin
        cw_o.mem_write = 1'b1;
        cw_o.iord      = 1'b1;
        cw_o.retire    = 1'b1;
        cw_o.mem_gate  = 1'b1;
      end
      StExec: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_op    = AluFunct;
      end
      StRtEnd: begin
        cw_o.reg_dst   = 1'b1;
        cw_o.reg_write = 1'b1;
        cw_o.retire    = 1'b1;
      end
      StBeq, StBne: begin
        cw_o.alu_src_a     = 1'b1;
        cw_o.alu_op        = AluSub;
        cw_o.pc_write_cond = 1'b1;
        cw_o.pc_source     = PcSrcAluOut;
        cw_o.is_bne        = (state_i == StBne);
        cw_o.retire        = 1'b1;
      end
      StIExec: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SrcBImm;
        cw_o.alu_op    = imm_alu_op(opc_o);
        cw_o.ext_op    = !(opc_o inside {OpcAndi, OpcOri});
      end
      StIEnd: begin
        cw_o.reg_write = 1'b1;
        cw_o.alu_op    = imm_alu_op(opc_o);
        cw_o.ext_op    = !(opc_o inside {OpcAndi, OpcOri});
        cw_o.retire    = 1'b1;
      end
      StJump: begin
        cw_o.pc_write  = 1'b1;
        cw_o.pc_source = PcSrcJump;
        cw_o.retire    = 1'b1;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      StTrap: begin
        cw_o.pc_write  = 1'b1;
        cw_o.pc_source = PcSrcTrap;
        cw_o.illegal   = 1'b1;
        cw_o.trap      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_ext.sv
// Extended multicycle MIPS control FSM: state register, next-state, mem_ready gating and the
// retired-instruction counter. MC_CTRL_ILLEGAL_TRAP_EN routes illegal opcodes through TRAP.
module mc_control_ext
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input logic              clk,
  input logic              reset,
  mc_control_ext_if.master bus
);

  state_e           state_q, state_d;
  ctrl_t            cw;
  op_class_e        opc;
  logic             strobe_ok, ir_write, pc_write, retire, pc_sel;
  logic [CNT_W-1:0] instr_count_q;

  mc_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .state_i (state_q),
    .op_i    (bus.Op),
    .cw_o    (cw),
    .opc_o   (opc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StFetch;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opc)
          OpcLw, OpcSw:                      state_d = StMemAdr;
          OpcR:                              state_d = StExec;
          OpcBeq:                            state_d = StBeq;
          OpcBne:                            state_d = StBne;
          OpcAddi, OpcAndi, OpcOri, OpcSlti: state_d = StIExec;
          OpcJ:                              state_d = StJump;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:                           state_d = StTrap;
`else
          default:                           state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: state_d = (opc == OpcSw) ? StMemWr : StMemRd;
      StMemRd:  if (bus.mem_ready) state_d = StMemWb;
      StMemWr:  if (bus.mem_ready) state_d = StFetch;
      StExec:   state_d = StRtEnd;
      StIExec:  state_d = StIEnd;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    strobe_ok = !cw.mem_gate || bus.mem_ready;
    ir_write  = cw.ir_write & strobe_ok;
    pc_write  = cw.pc_write & strobe_ok;
    retire    = cw.retire & strobe_ok;
    pc_sel    = pc_write | (cw.pc_write_cond & (bus.Zero ^ cw.is_bne));
  end

  // Reset low forces every control output to zero regardless of the decoded state
  assign bus.IorD        = reset & cw.iord;
  assign bus.MemRead     = reset & cw.mem_read;
  assign bus.MemWrite    = reset & cw.mem_write;
  assign bus.MemtoReg    = reset & cw.mem_to_reg;
  assign bus.IRWrite     = reset & ir_write;
  assign bus.PCSource    = reset ? cw.pc_source : PcSrcAlu;
  assign bus.ALUSrcA     = reset & cw.alu_src_a;
  assign bus.ALUSrcB     = reset ? cw.alu_src_b : SrcBReg;
  assign bus.ExtOp       = reset & cw.ext_op;
  assign bus.RegDst      = reset & cw.reg_dst;
  assign bus.RegWrite    = reset & cw.reg_write;
  assign bus.PCSel       = reset & pc_sel;
  assign bus.ALUOp       = reset ? ALUOP_W'(cw.alu_op) : '0;
  assign bus.illegal_op  = reset & cw.illegal;
  assign bus.instr_count = instr_count_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.trap        = reset & cw.trap;
`endif

endmodule
